// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction fetch sequencer: fetches over a req/ack
// memory handshake and hands each instruction to decode over valid/ready.
module pc_fetch_sequencer #(
    parameter int                 ADDR_W     = 32,
    parameter int                 INSTR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FETCH  = 2'b01,
        S_ISSUE  = 2'b10,
        S_HALTED = 2'b11
    } state_e;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_RESET  = RESET_ADDR & WORD_MASK;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               accept;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign accept = (state_q == S_ISSUE) && instr_ready;

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    // halt takes priority over a simultaneous redirect
                    if (halt) begin
                        state_d = S_HALTED;
                    end else if (br_taken) begin
                        pc_d    = br_target & WORD_MASK;
                        state_d = S_FETCH;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            S_FETCH:  imem_req    = 1'b1;
            S_ISSUE:  instr_valid = 1'b1;
            S_HALTED: halted      = 1'b1;
            default:  ;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a vector table for the main flow plus
// hand-written sequences for address wrap and asynchronous reset mid-fetch.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        ack, ready, br, hlt;
    logic [31:0] rdata, tgt;

    logic        req_a, valid_a, halted_a;
    logic [31:0] addr_a, instr_a, pc_a;
    logic        req_b, valid_b, halted_b;
    logic [31:0] addr_b, instr_b, pc_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .RESET_ADDR(32'h0)) dut_a (
        .clk(clk), .rst(rst_a),
        .imem_req(req_a), .imem_addr(addr_a), .imem_ack(ack), .imem_rdata(rdata),
        .instr(instr_a), .instr_valid(valid_a), .instr_ready(ready),
        .br_taken(br), .br_target(tgt), .halt(hlt),
        .pc(pc_a), .halted(halted_a)
    );

    pc_fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .RESET_ADDR(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst(rst_b),
        .imem_req(req_b), .imem_addr(addr_b), .imem_ack(ack), .imem_rdata(rdata),
        .instr(instr_b), .instr_valid(valid_b), .instr_ready(ready),
        .br_taken(br), .br_target(tgt), .halt(hlt),
        .pc(pc_b), .halted(halted_b)
    );

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        br;
        logic [31:0] tgt;
        logic        halt;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic        e_halted;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic a, input logic [31:0] d, input logic rd,
                       input logic b, input logic [31:0] t, input logic h,
                       input logic er, input logic [31:0] ep, input logic ev,
                       input logic [31:0] ei, input logic eh);
        vec_t v;
        v.rst = r; v.ack = a; v.rdata = d; v.ready = rd; v.br = b; v.tgt = t; v.halt = h;
        v.e_req = er; v.e_pc = ep; v.e_valid = ev; v.e_instr = ei; v.e_halted = eh;
        tbl.push_back(v);
    endtask

    task automatic chk_a(input string tag, input vec_t v);
        chk({tag, " imem_req"},    {31'd0, req_a},    {31'd0, v.e_req});
        chk({tag, " imem_addr"},   addr_a,            v.e_pc);
        chk({tag, " pc"},          pc_a,              v.e_pc);
        chk({tag, " instr_valid"}, {31'd0, valid_a},  {31'd0, v.e_valid});
        chk({tag, " instr"},       instr_a,           v.e_instr);
        chk({tag, " halted"},      {31'd0, halted_a}, {31'd0, v.e_halted});
    endtask

    initial begin
        vec_t rs;
        rst_a = 1'b0; rst_b = 1'b0;
        ack = 1'b0; ready = 1'b0; br = 1'b0; hlt = 1'b0;
        rdata = '0; tgt = '0;

        // Reset values appear with no clock edge
        #1;
        rs.e_req = 0; rs.e_pc = 32'h0; rs.e_valid = 0; rs.e_instr = 32'h0; rs.e_halted = 0;
        chk_a("reset", rs);

        //  rst ack rdata         rdy br tgt           hlt | req pc            vld instr         hlt
        add(0, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0,          0, 32'h0,          0);
        add(0, 1, 32'h99,         1, 0, 32'h0,          0,   0, 32'h0,          0, 32'h0,          0);
        add(1, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0,          0, 32'h0,          0);
        add(1, 1, 32'h11,         0, 0, 32'h0,          0,   0, 32'h0,          1, 32'h11,         0);
        add(1, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h4,          0, 32'h11,         0);
        add(1, 1, 32'h22,         1, 0, 32'h0,          0,   0, 32'h4,          1, 32'h22,         0);
        add(1, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h8,          0, 32'h22,         0);
        // ack withheld at pc=8; ready/br/halt while not issuing have no effect
        add(1, 0, 32'h77,         1, 1, 32'h300,        1,   1, 32'h8,          0, 32'h22,         0);
        add(1, 0, 32'h77,         0, 0, 32'h0,          0,   1, 32'h8,          0, 32'h22,         0);
        add(1, 0, 32'h77,         1, 0, 32'h0,          0,   1, 32'h8,          0, 32'h22,         0);
        add(1, 0, 32'h77,         0, 1, 32'h300,        0,   1, 32'h8,          0, 32'h22,         0);
        add(1, 0, 32'h77,         1, 0, 32'h0,          1,   1, 32'h8,          0, 32'h22,         0);
        add(1, 1, 32'h33,         0, 0, 32'h0,          0,   0, 32'h8,          1, 32'h33,         0);
        add(1, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'hC,          0, 32'h33,         0);
        add(1, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,          0,   0, 32'hC,          1, 32'hDEAD_BEEF,  0);
        // stall in ISSUE: stray ack/br/halt ignored without ready
        add(1, 1, 32'h1234_5678,  0, 1, 32'h500,        1,   0, 32'hC,          1, 32'hDEAD_BEEF,  0);
        add(1, 1, 32'h1234_5678,  0, 0, 32'h0,          0,   0, 32'hC,          1, 32'hDEAD_BEEF,  0);
        add(1, 0, 32'h0,          0, 1, 32'h500,        0,   0, 32'hC,          1, 32'hDEAD_BEEF,  0);
        add(1, 0, 32'h0,          0, 0, 32'h0,          1,   0, 32'hC,          1, 32'hDEAD_BEEF,  0);
        // taken branch, low target bits cleared
        add(1, 0, 32'h0,          1, 1, 32'h0000_0103,  0,   1, 32'h100,        0, 32'hDEAD_BEEF,  0);
        add(1, 1, 32'h44,         0, 0, 32'h0,          0,   0, 32'h100,        1, 32'h44,         0);
        add(1, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h104,        0, 32'h44,         0);
        add(1, 1, 32'h55,         0, 0, 32'h0,          0,   0, 32'h104,        1, 32'h55,         0);
        // halt beats branch; halted state is sticky
        add(1, 0, 32'h0,          1, 1, 32'h200,        1,   0, 32'h104,        0, 32'h55,         1);
        add(1, 1, 32'h66,         1, 0, 32'h0,          0,   0, 32'h104,        0, 32'h55,         1);
        add(1, 1, 32'h66,         1, 1, 32'h200,        0,   0, 32'h104,        0, 32'h55,         1);
        add(0, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0,          0, 32'h0,          0);
        add(1, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0,          0, 32'h0,          0);

        foreach (tbl[i]) begin
            rst_a = tbl[i].rst; ack = tbl[i].ack; rdata = tbl[i].rdata; ready = tbl[i].ready;
            br = tbl[i].br; tgt = tbl[i].tgt; hlt = tbl[i].halt;
            @(posedge clk); #1;
            chk_a($sformatf("vec%0d", i), tbl[i]);
        end

        // Async reset from HALTED clears state immediately
        ready = 1'b1; hlt = 1'b1; ack = 1'b1; rdata = 32'hAB;
        @(posedge clk); #1;  // ISSUE
        @(posedge clk); #1;  // HALTED
        chk("halt again", {31'd0, halted_a}, 32'd1);
        #2 rst_a = 1'b0; #1;
        chk("async rst halted", {31'd0, halted_a}, 32'd0);
        chk("async rst pc", pc_a, 32'h0);
        ack = 1'b0; ready = 1'b0; hlt = 1'b0;

        // Wrap at top of address space and async reset mid-fetch
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("wrap fetch req", {31'd0, req_b}, 32'd1);
        chk("wrap fetch addr", addr_b, 32'hFFFF_FFFC);
        ack = 1'b1; rdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        chk("wrap issue valid", {31'd0, valid_b}, 32'd1);
        chk("wrap issue instr", instr_b, 32'hCAFE_0001);
        ack = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        chk("wrap next addr", addr_b, 32'h0);
        chk("wrap next req", {31'd0, req_b}, 32'd1);
        ready = 1'b0;
        #2 rst_b = 1'b0; #1;
        chk("midfetch rst req", {31'd0, req_b}, 32'd0);
        chk("midfetch rst pc", pc_b, 32'hFFFF_FFFC);
        chk("midfetch rst instr", instr_b, 32'h0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("restart addr", addr_b, 32'hFFFF_FFFC);
        chk("restart req", {31'd0, req_b}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
